// File: rtl/seq_symbol_serializer.sv
// -----------------------------------------------------------------------------
// seq_symbol_serializer
//
// Turns parallel words into a stream of 2-bit symbols, one per clock, for the
// seq input of the 2-bit sequence-detector FSM. A one-word holding register
// sits behind a valid/ready handshake, so consecutive words stream with no
// idle gap between them. While pause is high the stream is frozen. Cycles with
// no word symbol drive IDLE_SYM.
//
// Parameters:
//   WORD_W    input word width; must be even and >= 4 (SYMS = WORD_W/2)
//   IDLE_SYM  symbol driven on seq_out when no word is being shifted
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   din        parallel word to serialise
//   din_valid  din is presented
//   din_ready  holding register empty (a word is accepted on valid & ready)
//   pause      freezes the shifter and all registered outputs while high
//   seq_out    current symbol to the detector
//   seq_valid  seq_out carries a word symbol
//   done       high while the last symbol of a word is on seq_out
//   busy       shifter loaded or holding register full
//
// Build option:
//   SEQ_SERIAL_LSB_FIRST_EN  when defined, symbols leave LSB-first
//                            (symbol 0 = din[1:0]); otherwise MSB-first.
//                            Timing, handshake and done are the same either way.
// -----------------------------------------------------------------------------
module seq_symbol_serializer #(
  parameter int unsigned WORD_W   = 8,
  parameter logic [1:0]  IDLE_SYM = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              pause,
  output logic [1:0]        seq_out,
  output logic              seq_valid,
  output logic              done,
  output logic              busy
);

  localparam int unsigned     SYMS     = WORD_W / 2;
  localparam int unsigned     CNT_W    = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SYMS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Symbol at the head of a (partially shifted) word, and the word with that
  // symbol removed. The shifter always presents its head symbol next.
  function automatic logic [1:0] head_sym(input logic [WORD_W-1:0] w);
`ifdef SEQ_SERIAL_LSB_FIRST_EN
    return w[1:0];
`else
    return w[WORD_W-1:WORD_W-2];
`endif
  endfunction

  function automatic logic [WORD_W-1:0] drop_head(input logic [WORD_W-1:0] w);
`ifdef SEQ_SERIAL_LSB_FIRST_EN
    return w >> 2;
`else
    return w << 2;
`endif
  endfunction

  logic [0:0]        state,     state_d;
  logic [WORD_W-1:0] hold,      hold_d;
  logic              hold_full, hold_full_d;
  logic [WORD_W-1:0] shreg,     shreg_d;
  logic [CNT_W-1:0]  sym_cnt,   sym_cnt_d;
  logic [1:0]        seq_out_d;
  logic              seq_valid_d, done_d, busy_d;
  logic              accept, load;

  assign din_ready = ~hold_full;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // block leaves one unassigned and no latch is inferred.
    state_d     = state;
    hold_d      = hold;
    hold_full_d = hold_full;
    shreg_d     = shreg;
    sym_cnt_d   = sym_cnt;
    seq_out_d   = seq_out;
    seq_valid_d = seq_valid;
    done_d      = done;
    load        = 1'b0;

    // Accept needs an empty hold and a transfer needs a full one, so the two
    // never coincide on the same edge.
    accept = din_valid & ~hold_full;

    if (!pause) begin
      if (state == ST_IDLE) begin
        load = hold_full;
      end else if (sym_cnt != '0) begin
        seq_out_d = head_sym(shreg);
        shreg_d   = drop_head(shreg);
        sym_cnt_d = sym_cnt - CNT_ONE;
        done_d    = (sym_cnt == CNT_ONE);
      end else if (hold_full) begin
        load = 1'b1;                      // chain the next word, no gap
      end else begin
        state_d     = ST_IDLE;
        seq_out_d   = IDLE_SYM;
        seq_valid_d = 1'b0;
        done_d      = 1'b0;
      end
    end

    if (load) begin
      state_d     = ST_SHIFT;
      seq_out_d   = head_sym(hold);
      shreg_d     = drop_head(hold);
      sym_cnt_d   = CNT_LOAD;
      seq_valid_d = 1'b1;
      done_d      = 1'b0;                 // SYMS >= 2, symbol 0 is never last
      hold_full_d = 1'b0;
    end

    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    busy_d = (state_d == ST_SHIFT) | hold_full_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      // NOTE: the data registers are reset as well; they are only a few flops
      // and it keeps stale words from ever being observable after reset.
      hold      <= '0;
      shreg     <= '0;
      sym_cnt   <= '0;
      seq_out   <= IDLE_SYM;
      seq_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      hold_full <= hold_full_d;
      hold      <= hold_d;
      shreg     <= shreg_d;
      sym_cnt   <= sym_cnt_d;
      seq_out   <= seq_out_d;
      seq_valid <= seq_valid_d;
      done      <= done_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_seq_symbol_serializer.sv
// -----------------------------------------------------------------------------
// Testbench for seq_symbol_serializer.
// A word-level reference model (queues of accepted words and pending symbols)
// advances on every rising edge; a monitor compares every DUT output against
// it on the falling edge. Directed scenarios add hand-derived sequence checks,
// followed by a randomised phase with random gaps and random pause.
// -----------------------------------------------------------------------------
module tb_seq_symbol_serializer;

  localparam int         WORD_W   = 8;
  localparam int         SYMS     = WORD_W / 2;
  localparam logic [1:0] IDLE_SYM = 2'b00;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [WORD_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready;
  logic              pause = 1'b0;
  logic [1:0]        seq_out;
  logic              seq_valid;
  logic              done;
  logic              busy;

  seq_symbol_serializer #(.WORD_W(WORD_W), .IDLE_SYM(IDLE_SYM)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .pause     (pause),
    .seq_out   (seq_out),
    .seq_valid (seq_valid),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int unsigned word_q[$];   // accepted words not yet started (the hold)
  logic [1:0]  sym_q[$];    // remaining symbols of the word being sent
  logic [1:0]  m_sym   = IDLE_SYM;
  bit          m_valid = 1'b0;
  bit          m_done  = 1'b0;
  bit          m_acc;

  function automatic void expand(input int unsigned w);
    for (int i = 0; i < SYMS; i++) begin
`ifdef SEQ_SERIAL_LSB_FIRST_EN
      sym_q.push_back(2'((w >> (2 * i)) & 3));
`else
      sym_q.push_back(2'((w >> (WORD_W - 2 - 2 * i)) & 3));
`endif
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        word_q.delete();
        sym_q.delete();
        m_sym   = IDLE_SYM;
        m_valid = 1'b0;
        m_done  = 1'b0;
      end else begin
        m_acc = din_valid && (word_q.size() == 0);
        if (!pause) begin
          if (sym_q.size() > 0) begin
            m_sym   = sym_q.pop_front();
            m_valid = 1'b1;
            m_done  = (sym_q.size() == 0);
          end else if (word_q.size() > 0) begin
            expand(word_q.pop_front());
            m_sym   = sym_q.pop_front();
            m_valid = 1'b1;
            m_done  = 1'b0;
          end else begin
            m_sym   = IDLE_SYM;
            m_valid = 1'b0;
            m_done  = 1'b0;
          end
        end
        if (m_acc) word_q.push_back(32'(din));
      end
    end
  end

  // -------------------------------------------------------------- monitor
  int          valid_cnt = 0;
  int          done_cnt  = 0;
  logic [31:0] obs_pack  = '0;   // every valid symbol seen, newest in [1:0]

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("seq_out",   32'(seq_out),   32'(m_sym));
        check("seq_valid", 32'(seq_valid), 32'(m_valid));
        check("done",      32'(done),      32'(m_done));
        check("busy",      32'(busy),      32'(m_valid || (word_q.size() != 0)));
        check("din_ready", 32'(din_ready), 32'(word_q.size() == 0));
        if (seq_valid) begin
          valid_cnt++;
          obs_pack = {obs_pack[29:0], seq_out};
        end
        if (done) done_cnt++;
      end
    end
  end

  // ---------------------------------------------------------------- pause
  bit pause_en = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (pause_en) pause = ($urandom_range(0, 3) == 0);
    end
  end

  // --------------------------------------------------------------- driver
  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send(input logic [WORD_W-1:0] w);
    logic rdy;
    bit   ok;
    ok        = 1'b0;
    din       = w;
    din_valid = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      rdy = din_ready;
      @(posedge clk);
      if (rdy) ok = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    if (!ok) check("send_accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int v0, d0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(3);
    check("rst_seq_out",   32'(seq_out),   32'(IDLE_SYM));
    check("rst_seq_valid", 32'(seq_valid), 32'(0));
    check("rst_done",      32'(done),      32'(0));
    check("rst_busy",      32'(busy),      32'(0));
    check("rst_din_ready", 32'(din_ready), 32'(1));
    rst = 1'b0;
    idle(2);

    // Single word
    v0 = valid_cnt; d0 = done_cnt; obs_pack = '0;
    send(8'hE4);
    idle(8);
    check("single_len",  32'(valid_cnt - v0), 32'(4));
    check("single_done", 32'(done_cnt - d0),  32'(1));
`ifdef SEQ_SERIAL_LSB_FIRST_EN
    check("single_syms", obs_pack & 32'hFF, 32'h1B);
`else
    check("single_syms", obs_pack & 32'hFF, 32'hE4);
`endif

    // Back-to-back with backpressure
    v0 = valid_cnt; d0 = done_cnt; obs_pack = '0;
    send(8'hE4);
    send(8'h1B);
    check("b2b_ready_low", 32'(din_ready), 32'(0));
    check("b2b_busy",      32'(busy),      32'(1));
    idle(2);
    check("b2b_ready_still_low", 32'(din_ready), 32'(0));
    idle(1);
    check("b2b_ready_back", 32'(din_ready), 32'(1));
    idle(8);
    check("b2b_len",  32'(valid_cnt - v0), 32'(8));
    check("b2b_done", 32'(done_cnt - d0),  32'(2));
`ifdef SEQ_SERIAL_LSB_FIRST_EN
    check("b2b_syms", obs_pack & 32'hFFFF, 32'h1BE4);
`else
    check("b2b_syms", obs_pack & 32'hFFFF, 32'hE41B);
`endif

    // Pause for 3 cycles on the second symbol
    v0 = valid_cnt; d0 = done_cnt; obs_pack = '0;
    send(8'hE4);
    idle(2);
`ifdef SEQ_SERIAL_LSB_FIRST_EN
    check("pause_sym1", 32'(seq_out), 32'(2'b01));
`else
    check("pause_sym1", 32'(seq_out), 32'(2'b10));
`endif
    pause = 1'b1;
    idle(3);
    pause = 1'b0;
    idle(6);
    check("pause_len",  32'(valid_cnt - v0), 32'(7));
    check("pause_done", 32'(done_cnt - d0),  32'(1));
`ifdef SEQ_SERIAL_LSB_FIRST_EN
    check("pause_syms", obs_pack & 32'h3FFF, 32'h055B);
`else
    check("pause_syms", obs_pack & 32'h3FFF, 32'h3AA4);
`endif

    // Reset mid-word with a second word in hold
    send(8'hE4);
    send(8'h1B);
    check("mid_busy",  32'(busy),      32'(1));
    check("mid_ready", 32'(din_ready), 32'(0));
    #1 rst = 1'b1;
    #1;
    check("mid_rst_seq_out",   32'(seq_out),   32'(IDLE_SYM));
    check("mid_rst_seq_valid", 32'(seq_valid), 32'(0));
    check("mid_rst_done",      32'(done),      32'(0));
    check("mid_rst_ready",     32'(din_ready), 32'(1));
    check("mid_rst_busy",      32'(busy),      32'(0));
    idle(2);
    rst = 1'b0;
    v0 = valid_cnt;
    idle(10);
    check("post_rst_silent", 32'(valid_cnt - v0), 32'(0));

    // Randomised traffic with random pause
    pause_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      idle($urandom_range(0, 3));
      send(WORD_W'($urandom));
    end
    pause_en = 1'b0;
    pause    = 1'b0;
    for (int c = 0; c < 200 && (m_valid || word_q.size() != 0); c++) idle(1);
    check("drain", 32'(m_valid || word_q.size() != 0), 32'(0));
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_symbol_serializer.md
Name: seq_symbol_serializer

Overview:
- Upstream feeder for the 2-bit sequence-detector FSM; converts parallel words into a stream of 2-bit symbols, one per clock, on the detector's seq input.
- Valid/ready input with a one-word holding register, so consecutive words stream with no idle gap.
- A pause input freezes the stream; idle cycles drive a parameterised idle symbol.

Parameters:
- WORD_W, 8, input word width in bits; must be even and >= 4; SYMS = WORD_W/2 symbols per word.
- IDLE_SYM, 2'b00, symbol driven on seq_out when no word is being shifted.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WORD_W  parallel word to serialise.
- din_valid  input  1  din is presented.
- din_ready  output  1  holding register empty; word accepted on an edge where din_valid & din_ready.
- pause  input  1  freeze the shifter and outputs while high.
- seq_out  output  2  current symbol to the detector's seq input.
- seq_valid  output  1  seq_out carries a word symbol (not IDLE_SYM).
- done  output  1  high for the cycle in which the last symbol of a word is on seq_out.
- busy  output  1  shifter loaded or holding register full.

Behaviour:
- All outputs registered except din_ready, which is ~hold_full.
- Reset (async, immediate): seq_out = IDLE_SYM, seq_valid = 0, done = 0, busy = 0, hold empty (din_ready = 1), shifter empty, state IDLE. Reset mid-word discards both the shifter and hold contents, and no further symbols of those words appear.
- Accept: on an edge with din_valid & din_ready, din is written to hold, and hold_full = 1.
- States:
  - IDLE: on an edge with hold_full & !pause, move hold to the shifter, clear hold_full, present symbol 0 (din[WORD_W-1:WORD_W-2]), set seq_valid = 1, load sym_cnt = SYMS-1, go to SHIFT.
  - SHIFT: on each edge with !pause, present the next symbol and decrement sym_cnt.
  - When sym_cnt == 0 (last symbol on seq_out): done = 1. On the next !pause edge, if hold_full, load the next word and present its symbol 0 with no gap; otherwise go to IDLE with seq_out = IDLE_SYM and seq_valid = 0.
- Latency: a word accepted at edge N shows its first symbol after edge N+1 (if IDLE and no pause). Each word occupies SYMS consecutive unpaused cycles.
- Pause: while high, state, sym_cnt, seq_out, seq_valid and done all hold their values. din may still be accepted into an empty hold.
- Hold-to-shifter transfer clears hold_full, so din_ready rises the following cycle. A new accept and a transfer on the same edge cannot occur, because ready is low while hold is full.
- done is never asserted while seq_valid = 0.
- busy = (state == SHIFT) | hold_full.

Optional Feature:
- Macro SEQ_SERIAL_LSB_FIRST_EN.
- Defined: symbol order is LSB-first; symbol 0 = din[1:0] and the last symbol = din[WORD_W-1:WORD_W-2].
- Undefined (default): MSB-first as described above.
- Timing, handshake and done are identical in both cases.

Test Plan:
- Single word: WORD_W = 8, din = 8'hE4 accepted at edge 1 -> seq_out 11, 10, 01, 00 after edges 2-5, seq_valid = 1 for those 4 cycles, done high only with 00, then seq_out = 00 and seq_valid = 0.
- Back-to-back: 8'hE4 then 8'h1B held valid -> 8 consecutive valid symbols 11, 10, 01, 00, 00, 01, 10, 11 with no gap. din_ready drops after the second word is accepted and returns when it transfers. done is high twice.
- Pause: assert pause for 3 cycles while 10 is shown for 8'hE4 -> 10 is held for 4 cycles total and the sequence then continues with 01, 00. Total word length is 7 cycles.
- Reset mid-word: assert rst while the 2nd symbol of 8'hE4 is shown, with 8'h1B in hold -> seq_out = 00, seq_valid = 0, din_ready = 1, busy = 0 immediately; no symbols from either word appear after release.
- Macro defined: din = 8'hE4 -> 00, 01, 10, 11, with done on 11.
- Ready/backpressure: keep din_valid high with hold full during SHIFT -> din_ready = 0 and din is not taken until the transfer edge.
